// File: rtl/marlann_mem_arbiter_pkg.sv
// Shared types and constants for the MARLANN main-memory arbiter.
// Holds client encodings, bus widths, response lane offsets and the wait-counter helper.
package marlann_mem_arbiter_pkg;

    localparam int unsigned MemAddrW = 16;
    localparam int unsigned MemDataW = 64;
    localparam int unsigned MemBeW   = MemDataW / 8;
    localparam int unsigned QDataW   = 16;
    localparam int unsigned SDataW   = 32;
    localparam int unsigned QLaneOff = 0;
    localparam int unsigned SLaneOff = 0;
    localparam int unsigned StarveW  = 8;

    typedef enum logic [1:0] {
        ArbNone = 2'd0,
        ArbCmem = 2'd1,
        ArbQmem = 2'd2,
        ArbSmem = 2'd3
    } arb_client_e;

    // Wait counter: clears on grant or dropped request, counts only while eligible.
    function automatic logic [StarveW-1:0] wait_cnt_next(
        input logic [StarveW-1:0] cnt,
        input logic               req,
        input logic               pend,
        input logic               granted,
        input logic [StarveW-1:0] limit
    );
        if (!req || granted) begin
            return '0;
        end else if (!pend && (cnt != limit)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/marlann_arb_resp_pipe.sv
// Fixed-latency response tracker: a 1-bit shift register with asynchronous clear.
// pend_o is high while any access is in flight, including the done cycle.
module marlann_arb_resp_pipe #(
    parameter int unsigned Depth = 2
) (
    input  logic clock_i,
    input  logic resetn_i,
    input  logic issue_i,
    output logic pend_o,
    output logic done_o
);

    logic [Depth-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = {sr_q[Depth-2:0], issue_i};
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign pend_o = |sr_q;
    assign done_o = sr_q[Depth-1];

endmodule

// File: rtl/marlann_mem_arbiter.sv
// Single-port main-memory arbiter for compute, QPI host and sequencer clients.
// Define MARLANN_ARB_RR_EN to alternate qmem/smem when both qualify (default: qmem first).
module marlann_mem_arbiter
    import marlann_mem_arbiter_pkg::*;
#(
    parameter int unsigned QLatency    = 2,
    parameter int unsigned SLatency    = 3,
    parameter int unsigned StarveLimit = 255
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                c_ren_i,
    input  logic [MemBeW-1:0]   c_wen_i,
    input  logic [MemAddrW-1:0] c_addr_i,
    input  logic [MemDataW-1:0] c_wdata_i,
    output logic [MemDataW-1:0] c_rdata_o,
    input  logic                q_req_i,
    input  logic [1:0]          q_wen_i,
    input  logic [MemAddrW-1:0] q_addr_i,
    input  logic [QDataW-1:0]   q_wdata_i,
    output logic                q_done_o,
    output logic [QDataW-1:0]   q_rdata_o,
    input  logic                s_req_i,
    input  logic [MemAddrW-1:0] s_addr_i,
    output logic                s_ready_o,
    output logic [SDataW-1:0]   s_rdata_o,
    output logic [MemAddrW-1:0] mem_addr_o,
    output logic [MemBeW-1:0]   mem_wen_o,
    output logic [MemDataW-1:0] mem_wdata_o,
    input  logic [MemDataW-1:0] mem_rdata_i,
    output logic                starve_o
);

    localparam logic [StarveW-1:0] Limit = StarveW'(StarveLimit);

    arb_client_e         grant;
    logic                c_act, q_ok, s_ok, q_pend, s_pend;
    logic [MemAddrW-1:0] mem_addr_q, mem_addr_d;
    logic [MemBeW-1:0]   mem_wen_q, mem_wen_d;
    logic [MemDataW-1:0] mem_wdata_q, mem_wdata_d;
    logic [StarveW-1:0]  q_cnt_q, q_cnt_d, s_cnt_q, s_cnt_d;
    logic                starve_q, starve_d;

    assign c_act = c_ren_i || (|c_wen_i);
    assign q_ok  = q_req_i && !q_pend;
    assign s_ok  = s_req_i && !s_pend;

`ifdef MARLANN_ARB_RR_EN
    logic rr_q, rr_d;

    assign rr_d = rr_q ^ ((grant == ArbQmem) || (grant == ArbSmem));

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Compute always wins; it has no backpressure.
    always_comb begin
        grant = ArbNone;
        if (c_act) begin
            grant = ArbCmem;
        end else if (q_ok && s_ok) begin
`ifdef MARLANN_ARB_RR_EN
            grant = rr_q ? ArbSmem : ArbQmem;
`else
            grant = ArbQmem;
`endif
        end else if (q_ok) begin
            grant = ArbQmem;
        end else if (s_ok) begin
            grant = ArbSmem;
        end
    end

    always_comb begin
        mem_addr_d  = c_addr_i;
        mem_wen_d   = '0;
        mem_wdata_d = c_wdata_i;
        unique case (grant)
            ArbCmem: mem_wen_d = c_wen_i;
            ArbQmem: begin
                mem_addr_d  = q_addr_i;
                mem_wen_d   = {{(MemBeW-2){1'b0}}, q_wen_i};
                mem_wdata_d = {{(MemDataW-QDataW){1'b0}}, q_wdata_i};
            end
            ArbSmem: begin
                mem_addr_d  = s_addr_i;
                mem_wdata_d = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        q_cnt_d  = wait_cnt_next(q_cnt_q, q_req_i, q_pend, grant == ArbQmem, Limit);
        s_cnt_d  = wait_cnt_next(s_cnt_q, s_req_i, s_pend, grant == ArbSmem, Limit);
        starve_d = (q_cnt_d == Limit) || (s_cnt_d == Limit);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mem_addr_q  <= '0;
            mem_wen_q   <= '0;
            mem_wdata_q <= '0;
            q_cnt_q     <= '0;
            s_cnt_q     <= '0;
            starve_q    <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            q_cnt_q     <= q_cnt_d;
            s_cnt_q     <= s_cnt_d;
            starve_q    <= starve_d;
        end
    end

    marlann_arb_resp_pipe #(
        .Depth (QLatency)
    ) u_q_pipe (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .issue_i  (grant == ArbQmem),
        .pend_o   (q_pend),
        .done_o   (q_done_o)
    );

    marlann_arb_resp_pipe #(
        .Depth (SLatency)
    ) u_s_pipe (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .issue_i  (grant == ArbSmem),
        .pend_o   (s_pend),
        .done_o   (s_ready_o)
    );

    assign mem_addr_o  = mem_addr_q;
    assign mem_wen_o   = mem_wen_q;
    assign mem_wdata_o = mem_wdata_q;
    assign starve_o    = starve_q;
    assign c_rdata_o   = mem_rdata_i;
    assign q_rdata_o   = mem_rdata_i[QLaneOff +: QDataW];
    assign s_rdata_o   = mem_rdata_i[SLaneOff +: SDataW];

endmodule

// File: tb/tb_marlann_mem_arbiter.sv
// Scoreboard bench for marlann_mem_arbiter: directed stimulus pushes expected q_done/s_ready
// events; a negedge monitor pops and checks them. Memory model has two-cycle read latency.
module tb_marlann_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        c_ren;
    logic [7:0]  c_wen;
    logic [15:0] c_addr;
    logic [63:0] c_wdata, c_rdata;
    logic        q_req;
    logic [1:0]  q_wen;
    logic [15:0] q_addr, q_wdata, q_rdata;
    logic        q_done;
    logic        s_req;
    logic [15:0] s_addr;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wen;
    logic [63:0] mem_wdata, mem_rdata;
    logic        starve;

    always #5 clk = ~clk;

    marlann_mem_arbiter #(
        .QLatency    (2),
        .SLatency    (3),
        .StarveLimit (255)
    ) dut (
        .clock_i     (clk),
        .resetn_i    (resetn),
        .c_ren_i     (c_ren),
        .c_wen_i     (c_wen),
        .c_addr_i    (c_addr),
        .c_wdata_i   (c_wdata),
        .c_rdata_o   (c_rdata),
        .q_req_i     (q_req),
        .q_wen_i     (q_wen),
        .q_addr_i    (q_addr),
        .q_wdata_i   (q_wdata),
        .q_done_o    (q_done),
        .q_rdata_o   (q_rdata),
        .s_req_i     (s_req),
        .s_addr_i    (s_addr),
        .s_ready_o   (s_ready),
        .s_rdata_o   (s_rdata),
        .mem_addr_o  (mem_addr),
        .mem_wen_o   (mem_wen),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .starve_o    (starve)
    );

    // Memory model: byte-lane writes, two-stage registered read.
    logic [63:0] mem [0:1023];
    logic [63:0] rd1, rd2;
    bit          preload_done;

    always @(posedge clk) begin
        if (!preload_done) begin
            mem[16]      <= 64'h0000_0000_1234_5678;
            mem[64]      <= 64'h0;
            mem[512]     <= 64'hCAFE_F00D_A5A5_5A5A;
            preload_done <= 1'b1;
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (mem_wen[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        rd1 <= mem[mem_addr[9:0]];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t q_exp[$];
    exp_t s_exp[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q_done) begin
            if (q_exp.size() == 0) begin
                check("q_done_unexpected", {63'h0, q_done}, 64'h0);
            end else begin
                mon_e = q_exp.pop_front();
                check("q_done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        if (s_ready) begin
            if (s_exp.size() == 0) begin
                check("s_ready_unexpected", {63'h0, s_ready}, 64'h0);
            end else begin
                mon_e = s_exp.pop_front();
                check("s_ready_cycle", 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.chk) check("s_rdata", {32'h0, s_rdata}, {32'h0, mon_e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic s_fetch(input logic [15:0] addr, input logic [31:0] data);
        s_req  = 1'b1;
        s_addr = addr;
        s_exp.push_back('{cyc: cyc + 3, data: data, chk: 1'b1});
        repeat (4) step();
        s_req = 1'b0;
    endtask

    int    t0;
    string pat;
    byte   ch;
    logic [15:0] exp_addr;

    initial begin
        // Reset with every request asserted.
        resetn = 1'b0;
        c_ren = 1'b1; c_wen = 8'hFF; c_addr = 16'h1111; c_wdata = 64'h55;
        q_req = 1'b1; q_wen = 2'b11; q_addr = 16'h2222; q_wdata = 16'h3333;
        s_req = 1'b1; s_addr = 16'h4444;
        repeat (3) step();
        check("rst_mem_wen", {56'h0, mem_wen}, 64'h0);
        check("rst_mem_addr", {48'h0, mem_addr}, 64'h0);
        check("rst_q_done", {63'h0, q_done}, 64'h0);
        check("rst_s_ready", {63'h0, s_ready}, 64'h0);
        check("rst_starve", {63'h0, starve}, 64'h0);
        c_ren = 1'b0; c_wen = 8'h0; c_addr = 16'h0777; c_wdata = 64'h0;
        q_req = 1'b0; q_wen = 2'b00; s_req = 1'b0;
        resetn = 1'b1;
        repeat (2) step();

        // Single qmem write.
        q_req = 1'b1; q_wen = 2'b11; q_addr = 16'h0040; q_wdata = 16'hBEEF;
        t0 = cyc;
        q_exp.push_back('{cyc: t0 + 2, data: 32'h0, chk: 1'b0});
        step();
        check("q_wr_mem_addr", {48'h0, mem_addr}, 64'h0040);
        check("q_wr_mem_wen", {56'h0, mem_wen}, 64'h03);
        check("q_wr_mem_wdata", mem_wdata, 64'hBEEF);
        step();
        step();
        check("q_no_regrant_addr", {48'h0, mem_addr}, 64'h0777);
        check("q_no_regrant_wen", {56'h0, mem_wen}, 64'h0);
        q_req = 1'b0; q_wen = 2'b00;
        repeat (2) step();

        // Sequencer fetches, including readback of the qmem write.
        s_fetch(16'h0010, 32'h1234_5678);
        step();
        s_fetch(16'h0040, 32'h0000_BEEF);
        step();

        // Compute hogs the port for 300 cycles.
        c_ren = 1'b1; c_addr = 16'h0300;
        q_req = 1'b1; q_addr = 16'h0040; q_wen = 2'b00;
        repeat (254) step();
        check("starve_before_limit", {63'h0, starve}, 64'h0);
        step();
        check("starve_at_limit", {63'h0, starve}, 64'h1);
        repeat (44) step();
        check("starve_held", {63'h0, starve}, 64'h1);
        check("hog_mem_addr", {48'h0, mem_addr}, 64'h0300);
        step();
        c_ren = 1'b0; c_addr = 16'h0777;
        q_exp.push_back('{cyc: cyc + 2, data: 32'h0, chk: 1'b0});
        step();
        check("q_grant_after_hog", {48'h0, mem_addr}, 64'h0040);
        check("starve_cleared", {63'h0, starve}, 64'h0);
        repeat (2) step();
        q_req = 1'b0;
        repeat (2) step();

        // qmem and smem contend with compute idle.
`ifdef MARLANN_ARB_RR_EN
        pat = "qs-q-sq--sq--sq-";
`else
        pat = "qs-q-sq--qs-q-sq";
`endif
        q_req = 1'b1; q_addr = 16'h0100; q_wen = 2'b00;
        s_req = 1'b1; s_addr = 16'h0200;
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            ch = pat[i];
            if (ch == "q") q_exp.push_back('{cyc: t0 + i + 2, data: 32'h0, chk: 1'b0});
            if (ch == "s") s_exp.push_back('{cyc: t0 + i + 3, data: 32'hA5A5_5A5A, chk: 1'b1});
        end
        for (int i = 0; i < 16; i++) begin
            step();
            ch = pat[i];
            exp_addr = (ch == "q") ? 16'h0100 : (ch == "s") ? 16'h0200 : 16'h0777;
            check($sformatf("contend_grant_%0d", i), {48'h0, mem_addr}, {48'h0, exp_addr});
        end
        q_req = 1'b0; s_req = 1'b0;
        repeat (6) step();

        // Reset one cycle after a qmem grant: no late q_done.
        q_req = 1'b1; q_wen = 2'b11; q_addr = 16'h0050; q_wdata = 16'h1234;
        step();
        check("pre_rst_mem_wen", {56'h0, mem_wen}, 64'h03);
        resetn = 1'b0;
        #1;
        check("rst_async_mem_wen", {56'h0, mem_wen}, 64'h0);
        q_req = 1'b0; q_wen = 2'b00;
        repeat (2) step();
        resetn = 1'b1;
        repeat (5) step();
        q_req = 1'b1; q_addr = 16'h0060;
        q_exp.push_back('{cyc: cyc + 2, data: 32'h0, chk: 1'b0});
        step();
        check("post_rst_q_grant", {48'h0, mem_addr}, 64'h0060);
        repeat (2) step();
        q_req = 1'b0;
        repeat (3) step();

        check("q_exp_drained", 64'(q_exp.size()), 64'h0);
        check("s_exp_drained", 64'(s_exp.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
